divisor_secuencial: RTL and testbench
=====================================

Name: divisor_secuencial

Overview:
Sequential restoring divider, the inverse of the team's 8x8 shift-add multiplicador. It takes a 16-bit dividend and an 8-bit divisor, and produces quotient and remainder one bit per clock. It uses the same start/done handshake as multiplicador, so a bench can chain them: A*B -> divisor_secuencial -> A, remainder 0.

Parameters:
WIDTH_N, 16, dividend and quotient width
WIDTH_D, 8, divisor and remainder width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividendo  input  WIDTH_N  dividend, captured on start
divisor  input  WIDTH_D  divisor, captured on start
cociente  output  WIDTH_N  quotient, valid when done=1 and held afterwards
residuo  output  WIDTH_D  remainder, valid when done=1 and held afterwards
done  output  1  one-cycle pulse, results valid
ocupado  output  1  high in CALC and FIN
div_cero  output  1  divisor was 0; valid with done, held until next start

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n); it is fixed as such.
- Reset, asserted at any time including mid-operation:
  - state goes to IDLE.
  - cociente, residuo, done, ocupado, div_cero all 0.
  - internal registers cleared.
  - no partial result is visible after reset.
- States: IDLE, CALC, FIN (typedef estado_t).
- IDLE with start=1 at edge E0:
  - latch dividendo into shift register q and divisor into d.
  - clear partial remainder r (WIDTH_D+1 bits).
  - load iteration counter = WIDTH_N-1.
  - if divisor==0, go to FIN with div_cero=1, cociente all ones, residuo = dividendo[WIDTH_D-1:0]; otherwise go to CALC.
- CALC, per edge:
  - t = {r[WIDTH_D-1:0], q[MSB]}.
  - if t >= {1'b0,d}: r = t - d and shift 1 into q LSB; else r = t and shift 0.
  - q shifts left.
  - when counter==0, go to FIN; otherwise decrement.
  - exactly WIDTH_N iterations.
- FIN: done=1 for exactly one cycle; cociente=q and residuo=r[WIDTH_D-1:0] are registered on entry; next state is IDLE.
- Latency:
  - normal: done high after edge E0+WIDTH_N+1 (17 edges for defaults).
  - divisor zero: done high after edge E0+1.
- Outputs hold their last value in IDLE until the next accepted start; they do not update during CALC.
- start while ocupado=1 is ignored, with no queuing. Operands may change freely after E0.
- start held high continuously: a new operation is accepted on the first IDLE cycle after FIN.
- Arithmetic is unsigned. Invariant: cociente*divisor + residuo == dividendo, with residuo < divisor.
- Quotient can never overflow because it is WIDTH_N wide.

Decomposition:
- Package divisor_pkg holds estado_t (IDLE, CALC, FIN) and localparam CNT_W = $clog2(WIDTH_N).
- One natural combinational sub-module, paso_resta: inputs r, q MSB and d; outputs the next r and the quotient bit. The main module keeps the FSM, counter and registers.
- Estimated 150-250 lines of RTL.

Test Plan:
- dividendo=5655, divisor=87, start pulse of 1 cycle -> done after 17 edges; cociente=65, residuo=0, div_cero=0. This inverts the multiplicador case 65*87.
- dividendo=2550, divisor=75 -> cociente=34, residuo=0. Then 1000/7 -> cociente=142, residuo=6.
- 65535/1 -> cociente=65535, residuo=0. Then 200/255 -> cociente=0, residuo=200.
- divisor=0, dividendo=0x1234 -> done after 1 edge; div_cero=1, cociente=0xFFFF, residuo=0x34, ocupado low the next cycle.
- start pulsed again at iteration 5 of 1000/7 -> ignored, result still 142 r 6. Then rst_n=0 at iteration 8 of a new operation -> all outputs 0 immediately, state IDLE, no done pulse. Then 5655/87 runs correctly.
- Random self-check, 1000 operand pairs with divisor!=0 -> cociente*divisor+residuo==dividendo and residuo<divisor on every done.

Source files
------------

// File: rtl/divisor_pkg.sv
// divisor_pkg: shared state type and default widths for the sequential divider
package divisor_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t;
    localparam int WIDTH_N_DEF = 16;
    localparam int WIDTH_D_DEF = 8;
    localparam int CNT_W = $clog2(WIDTH_N_DEF);
endpackage

// File: rtl/divisor_secuencial_paso_resta.sv
// paso_resta: one restoring-division step on the partial remainder
module paso_resta #(
    parameter int WIDTH_D = 8
) (
    input  logic [WIDTH_D:0]   r,
    input  logic               q_msb,
    input  logic [WIDTH_D-1:0] d,
    output logic [WIDTH_D:0]   r_sig,
    output logic               q_bit
);
    logic [WIDTH_D:0] t;
    // shift in the next dividend bit; a set r MSB means the shifted value already exceeds d
    always_comb begin
        t = {r[WIDTH_D-1:0], q_msb};
        q_bit = r[WIDTH_D] | (t >= {1'b0, d});
        r_sig = q_bit ? t - {1'b0, d} : t;
    end
endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: restoring divider, one quotient bit per clock, start/done handshake
module divisor_secuencial #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividendo,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_N-1:0] cociente,
    output logic [WIDTH_D-1:0] residuo,
    output logic               done,
    output logic               ocupado,
    output logic               div_cero
);
    import divisor_pkg::*;
    localparam int CW = $clog2(WIDTH_N);
    estado_t            estado, estado_sig;
    logic [WIDTH_N-1:0] q;
    logic [WIDTH_D-1:0] d;
    logic [WIDTH_D:0]   r, r_sig;
    logic               q_bit;
    logic [CW-1:0]      cnt;
    logic               dz;
    logic               cero;
    assign cero = divisor == '0;
    assign ocupado = estado != IDLE;
    paso_resta #(.WIDTH_D(WIDTH_D)) u_paso (
        .r(r),
        .q_msb(q[WIDTH_N-1]),
        .d(d),
        .r_sig(r_sig),
        .q_bit(q_bit)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else estado <= estado_sig;
    end
    // next state: a zero divisor skips the iterations and goes straight to FIN
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    estado_sig = start ? (cero ? FIN : CALC) : IDLE;
            CALC:    estado_sig = (cnt == '0) ? FIN : CALC;
            FIN:     estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end
    // datapath: capture operands, iterate, publish results on leaving FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            d        <= '0;
            r        <= '0;
            cnt      <= '0;
            dz       <= 1'b0;
            cociente <= '0;
            residuo  <= '0;
            div_cero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado)
                IDLE: if (start) begin
                    q   <= cero ? '1 : dividendo;
                    d   <= divisor;
                    r   <= cero ? {1'b0, dividendo[WIDTH_D-1:0]} : '0;
                    cnt <= CW'(WIDTH_N - 1);
                    dz  <= cero;
                end
                CALC: begin
                    r   <= r_sig;
                    q   <= {q[WIDTH_N-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                end
                FIN: begin
                    cociente <= q;
                    residuo  <= r[WIDTH_D-1:0];
                    div_cero <= dz;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: scoreboard bench for the sequential divider
module tb_divisor_secuencial;
    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividendo = '0;
    logic [7:0]  divisor = '0;
    logic [15:0] cociente;
    logic [7:0]  residuo;
    logic        done, ocupado, div_cero;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_push = 0;
    int   cyc = 0;
    int   t0 = 0;

    divisor_secuencial dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividendo(dividendo),
        .divisor(divisor),
        .cociente(cociente),
        .residuo(residuo),
        .done(done),
        .ocupado(ocupado),
        .div_cero(div_cero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done with empty scoreboard, expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cociente", 32'(cociente), 32'(e.q));
                chk("residuo", 32'(residuo), 32'(e.r));
                chk("div_cero", 32'(div_cero), 32'(e.dz));
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic [7:0] b, input logic [15:0] qe, input logic [7:0] re);
        exp_t e;
        e.q  = (b == 0) ? 16'hFFFF : qe;
        e.r  = (b == 0) ? a[7:0] : re;
        e.dz = (b == 0);
        sb.push_back(e);
        n_push++;
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [15:0] qe, input logic [7:0] re, input bit push);
        @(negedge clk);
        dividendo = a;
        divisor = b;
        start = 1'b1;
        if (push) push_exp(a, b, qe, re);
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat);
        @(negedge clk);
        chk("ocupado_busy", 32'(ocupado), 1);
        while (!done && (cyc - t0) < 40) @(negedge clk);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no done after %0d cycles, expected done at %0d", cyc - t0, lat);
        end else chk("latency", 32'(cyc - t0), 32'(lat));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cociente", 32'(cociente), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        rst_n = 1'b1;
        issue(5655, 87, 65, 0, 1);
        wait_done(17);
        issue(2550, 75, 34, 0, 1);
        wait_done(17);
        issue(1000, 7, 142, 6, 1);
        wait_done(17);
        issue(65535, 1, 65535, 0, 1);
        wait_done(17);
        issue(200, 255, 0, 200, 1);
        wait_done(17);
        issue(16'h1234, 0, 0, 0, 1);
        wait_done(1);
        @(negedge clk);
        chk("dz_ocupado_after", 32'(ocupado), 0);
        chk("dz_done_pulse", 32'(done), 0);
        chk("dz_held", 32'(div_cero), 1);
        issue(1000, 7, 142, 6, 1);
        repeat (5) @(negedge clk);
        dividendo = 9;
        divisor = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(17);
        repeat (25) @(negedge clk);
        chk("ignored_start_idle", 32'(ocupado), 0);
        issue(5655, 87, 0, 0, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_cociente", 32'(cociente), 0);
        chk("arst_residuo", 32'(residuo), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_ocupado", 32'(ocupado), 0);
        chk("arst_div_cero", 32'(div_cero), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_rst_idle", 32'(ocupado), 0);
        issue(5655, 87, 65, 0, 1);
        wait_done(17);
        begin
            int dn = 0;
            int lim = 0;
            @(negedge clk);
            dividendo = 100;
            divisor = 10;
            start = 1'b1;
            push_exp(100, 10, 10, 0);
            push_exp(100, 10, 10, 0);
            while (dn < 2 && lim < 100) begin
                @(negedge clk);
                lim++;
                if (done) dn++;
            end
            start = 1'b0;
            chk("held_start_dones", 32'(dn), 2);
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(1, 255));
            issue(a, b, a / 16'(b), 8'(a % 16'(b)), 1);
            wait_done(17);
        end
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("done_count", 32'(n_done), 32'(n_push));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
